// File: rtl/am2914_vpic.sv
// Vectored priority interrupt encoder: latches active-low requests, applies mask and
// status threshold, raises ir_ and returns the highest eligible vector on ACK.
module am2914_vpic #(
    parameter int unsigned NREQ = 8,
    parameter int unsigned VW   = 3
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [NREQ-1:0]   p_,
    input  logic [2:0]        ins,
    input  logic [NREQ-1:0]   m,
    output logic              ir_,
    output logic [VW-1:0]     vec,
    output logic              vld,
    output logic [NREQ-1:0]   msk,
    output logic [VW:0]       stat
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDM  = 3'd1,
        OP_SETM = 3'd2,
        OP_CLRM = 3'd3,
        OP_LDS  = 3'd4,
        OP_ACK  = 3'd5,
        OP_ENA  = 3'd6,
        OP_DIS  = 3'd7
    } op_e;

    logic [NREQ-1:0] preq_q, preq_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic [VW:0]     s_q, s_d;
    logic            en_q, en_d;
    logic            ir_n_q, ir_n_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic            vld_q, vld_d;

    logic [NREQ-1:0] pend;
    logic [VW-1:0]   hi_idx;
    logic            any_pend;
    op_e             op;

    assign op = op_e'(ins);

    // Eligibility and highest-index priority encode, all from current registers
    always_comb begin
        pend   = '0;
        hi_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            pend[i] = preq_q[i] & ~mask_q[i] & ((VW+1)'(i) >= s_q);
            if (pend[i]) hi_idx = VW'(i);
        end
        any_pend = |pend;
    end

    // Next-state for instruction execution and interrupt output
    always_comb begin
        preq_d = ~p_;
        mask_d = mask_q;
        s_d    = s_q;
        en_d   = en_q;
        ir_n_d = ~(en_q & any_pend);
        vec_d  = vec_q;
        vld_d  = 1'b0;
        unique case (op)
            OP_NOP:  ;
            OP_LDM:  mask_d = m;
            OP_SETM: mask_d = mask_q | m;
            OP_CLRM: mask_d = mask_q & ~m;
            OP_LDS: begin
                if (32'(m) > NREQ) s_d = (VW+1)'(NREQ);
                else               s_d = (VW+1)'(m);
            end
            OP_ACK: begin
                if (en_q & any_pend) begin
                    vec_d = hi_idx;
                    vld_d = 1'b1;
                    s_d   = (VW+1)'(hi_idx) + (VW+1)'(1);
                end
            end
            OP_ENA:  en_d = 1'b1;
            OP_DIS:  en_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            preq_q <= '0;
            mask_q <= '0;
            s_q    <= '0;
            en_q   <= 1'b0;
            ir_n_q <= 1'b1;
            vec_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            preq_q <= preq_d;
            mask_q <= mask_d;
            s_q    <= s_d;
            en_q   <= en_d;
            ir_n_q <= ir_n_d;
            vec_q  <= vec_d;
            vld_q  <= vld_d;
        end
    end

    assign ir_  = ir_n_q;
    assign vec  = vec_q;
    assign vld  = vld_q;
    assign msk  = mask_q;
    assign stat = s_q;

endmodule
